// File: rtl/hdmi_pixel_feeder.sv
// hdmi_pixel_feeder: fetches frame-buffer words from DDR in fixed bursts into a
// show-ahead FIFO and presents the head word to the HDMI timing generator.
// Optional build macro: HDMI_FEEDER_UNDERFLOW_COLOUR_EN -- when defined, an empty
// FIFO shows magenta (32'h00FF00FF) on hdmi_data instead of zero.
module hdmi_pixel_feeder #(
    parameter int                H_ACTIVE  = 640,
    parameter int                V_ACTIVE  = 480,
    parameter int                BURST_LEN = 64,
    parameter int                FIFO_AW   = 10,
    parameter int                PREFILL   = 512,
    parameter int                ADDR_W    = 28,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_ready,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_len,
    input  logic              rd_ack,
    input  logic              rd_valid,
    input  logic [31:0]       rd_data,
    input  logic              pixel_req,
    output logic [31:0]       hdmi_data,
    input  logic              tozero,
    output logic              first_frame,
    output logic [FIFO_AW:0]  fifo_level,
    output logic              underflow,
    output logic              sync_err
);

    localparam int FRAME_WORDS = H_ACTIVE * V_ACTIVE;
    localparam int FCNT_W      = $clog2(FRAME_WORDS + 1);
    localparam int LVL_W       = FIFO_AW + 1;

    localparam logic [LVL_W-1:0]  DEPTH       = LVL_W'(2 ** FIFO_AW);
    localparam logic [LVL_W-1:0]  BURST_LVL   = LVL_W'(BURST_LEN);
    localparam logic [LVL_W-1:0]  PREFILL_LVL = LVL_W'(PREFILL);
    localparam logic [LVL_W-1:0]  LVL_ONE     = LVL_W'(1);
    localparam logic [LVL_W-1:0]  LVL_TWO     = LVL_W'(2);
    localparam logic [7:0]        LAST_BEAT   = 8'(BURST_LEN - 1);
    localparam logic [FCNT_W-1:0] FRAME_CNT   = FCNT_W'(FRAME_WORDS);
    localparam logic [FCNT_W-1:0] BURST_CNT   = FCNT_W'(BURST_LEN);
    localparam logic [ADDR_W-1:0] BURST_ADDR  = ADDR_W'(BURST_LEN);

`ifdef HDMI_FEEDER_UNDERFLOW_COLOUR_EN
    localparam logic [31:0] EMPTY_WORD = 32'h00FF00FF;
`else
    localparam logic [31:0] EMPTY_WORD = 32'h0000_0000;
`endif

    typedef enum logic [2:0] {
        IDLE,
        WAIT_ROOM,
        REQ,
        DATA,
        FRAME_DONE
    } state_t;

    state_t state, state_nxt;

    logic [31:0]         mem [0:(2**FIFO_AW)-1];
    logic [FIFO_AW-1:0]  wr_ptr;
    logic [FIFO_AW-1:0]  rd_ptr;
    logic [FIFO_AW-1:0]  rd_ptr_nxt;
    logic [7:0]          beat_cnt;
    logic [FCNT_W-1:0]   frame_cnt;
    logic [FCNT_W-1:0]   frame_cnt_inc;
    logic                tozero_p1;
    logic                tozero_rise;
    logic                push;
    logic                pop;
    logic                burst_last;
    logic                rearm;

    assign rd_len        = 8'(BURST_LEN);
    assign push          = rd_valid && (fifo_level != DEPTH);
    assign pop           = pixel_req && (fifo_level != '0);
    assign rd_ptr_nxt    = rd_ptr + 1'b1;
    assign tozero_rise   = tozero && !tozero_p1;
    assign burst_last    = (state == DATA) && rd_valid && (beat_cnt == LAST_BEAT);
    assign frame_cnt_inc = frame_cnt + BURST_CNT;
    assign rearm         = (state == FRAME_DONE) && tozero_rise;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state and request output
    always_comb begin
        state_nxt = state;
        rd_req    = 1'b0;
        case (state)
            IDLE: begin
                if (frame_ready) state_nxt = WAIT_ROOM;
            end
            WAIT_ROOM: begin
                if ((DEPTH - fifo_level) >= BURST_LVL) state_nxt = REQ;
            end
            REQ: begin
                rd_req = 1'b1;
                if (rd_ack) state_nxt = DATA;
            end
            DATA: begin
                if (burst_last) begin
                    state_nxt = (frame_cnt_inc == FRAME_CNT) ? FRAME_DONE : WAIT_ROOM;
                end
            end
            FRAME_DONE: begin
                if (tozero_rise) state_nxt = WAIT_ROOM;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Burst address, beat and frame-word counters; tozero edge detect and sync error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr   <= BASE_ADDR;
            beat_cnt  <= '0;
            frame_cnt <= '0;
            tozero_p1 <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            tozero_p1 <= tozero;
            if (burst_last) begin
                rd_addr   <= rd_addr + BURST_ADDR;
                frame_cnt <= frame_cnt_inc;
                beat_cnt  <= '0;
            end else if ((state == DATA) && rd_valid) begin
                beat_cnt <= beat_cnt + 8'd1;
            end
            if (rearm) begin
                rd_addr   <= BASE_ADDR;
                frame_cnt <= '0;
            end
            if (tozero_rise && (state != FRAME_DONE) && (state != IDLE)) begin
                sync_err <= 1'b1;
            end
        end
    end

    // FIFO storage; no reset on the data array
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= rd_data;
    end

    // FIFO pointers, occupancy, head register, underflow and prefill flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_level  <= '0;
            hdmi_data   <= 32'h0000_0000;
            underflow   <= 1'b0;
            first_frame <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr_nxt;
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LVL_ONE;
                2'b01:   fifo_level <= fifo_level - LVL_ONE;
                default: fifo_level <= fifo_level;
            endcase
            // Head register tracks the word that will be at rd_ptr after this edge.
            // When the last stored word is popped while a new one arrives, the
            // arriving word is forwarded so the head is never stale.
            if (pop) begin
                if (fifo_level >= LVL_TWO) hdmi_data <= mem[rd_ptr_nxt];
                else if (push)             hdmi_data <= rd_data;
                else                       hdmi_data <= EMPTY_WORD;
            end else if (fifo_level != '0) begin
                hdmi_data <= mem[rd_ptr];
            end else begin
                hdmi_data <= EMPTY_WORD;
            end
            if (pixel_req && (fifo_level == '0)) underflow <= 1'b1;
            if (fifo_level >= PREFILL_LVL)       first_frame <= 1'b1;
        end
    end

    // Room gating in WAIT_ROOM means a word never arrives at a full FIFO
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(rd_valid && (fifo_level == DEPTH)));

endmodule

// File: tb/tb_hdmi_pixel_feeder.sv
// Scoreboard bench for hdmi_pixel_feeder with a reduced frame (32x4 words),
// 16-word bursts and a 64-word FIFO. A single negedge engine models DDR and
// the pixel consumer; the main sequence steers it through the scenarios.
module tb_hdmi_pixel_feeder;

    localparam int H      = 32;
    localparam int V      = 4;
    localparam int BURST  = 16;
    localparam int AW     = 6;
    localparam int PRE    = 32;
    localparam int ADDR_W = 28;
    localparam int FRAME  = H * V;

`ifdef HDMI_FEEDER_UNDERFLOW_COLOUR_EN
    localparam logic [31:0] EMPTY_VAL = 32'h00FF00FF;
`else
    localparam logic [31:0] EMPTY_VAL = 32'h0000_0000;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              frame_ready = 1'b0;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_len;
    logic              rd_ack = 1'b0;
    logic              rd_valid = 1'b0;
    logic [31:0]       rd_data = 32'h0;
    logic              pixel_req = 1'b0;
    logic [31:0]       hdmi_data;
    logic              tozero = 1'b0;
    logic              first_frame;
    logic [AW:0]       fifo_level;
    logic              underflow;
    logic              sync_err;

    hdmi_pixel_feeder #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .BURST_LEN(BURST),
        .FIFO_AW  (AW),
        .PREFILL  (PRE),
        .ADDR_W   (ADDR_W),
        .BASE_ADDR(28'd0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_ready(frame_ready),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_len     (rd_len),
        .rd_ack     (rd_ack),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .pixel_req  (pixel_req),
        .hdmi_data  (hdmi_data),
        .tozero     (tozero),
        .first_frame(first_frame),
        .fifo_level (fifo_level),
        .underflow  (underflow),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Controls written by the main sequence only
    int pop_mode   = 0;   // 0 none, 1 pop when level>=2, 2 pop when level>=1, 3 underflow probe
    int hold_token = 0;

    // State written by the engine only
    int                ddr_st      = 0;
    int                beat        = 0;
    int                hold_used   = 0;
    int                hold_cnt    = 0;
    int                hold_bad    = 0;
    bit                holding     = 1'b0;
    int                frames_done = 0;
    int                req_cycles  = 0;
    int                pop_cnt     = 0;
    logic [ADDR_W-1:0] cur_addr    = '0;
    logic [ADDR_W-1:0] exp_addr    = '0;
    logic [ADDR_W-1:0] hold_addr   = '0;
    logic [31:0]       sb[$];

    // DDR model and pixel consumer, both acting on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rd_ack    = 1'b0;
                rd_valid  = 1'b0;
                rd_data   = 32'h0;
                pixel_req = 1'b0;
                ddr_st    = 0;
                beat      = 0;
                holding   = 1'b0;
                exp_addr  = '0;
                sb.delete();
            end else begin
                bit ack_now;
                ack_now = 1'b0;
                if (rd_req) req_cycles++;
                if (ddr_st == 0) begin
                    rd_ack = 1'b0;
                    if (rd_req) begin
                        if (!holding && (hold_token != hold_used)) begin
                            holding   = 1'b1;
                            hold_used = hold_token;
                            hold_cnt  = 0;
                            hold_bad  = 0;
                            hold_addr = rd_addr;
                        end
                        if (holding) begin
                            if (rd_addr !== hold_addr) hold_bad++;
                            hold_cnt++;
                            if (hold_cnt > 20) begin
                                holding = 1'b0;
                                check_eq("ack_hold_stable", 64'(hold_bad), 64'd0);
                                ack_now = 1'b1;
                            end
                        end else begin
                            ack_now = 1'b1;
                        end
                        if (ack_now) begin
                            check_eq("rd_addr", 64'(rd_addr), 64'(exp_addr));
                            check_eq("rd_len", 64'(rd_len), 64'(BURST));
                            rd_ack   = 1'b1;
                            cur_addr = rd_addr;
                            ddr_st   = 1;
                        end
                    end else if (holding) begin
                        hold_bad++;
                    end
                end else if (ddr_st == 1) begin
                    rd_ack = 1'b0;
                    check_eq("rd_req_drop", 64'(rd_req), 64'd0);
                    beat   = 0;
                    ddr_st = 2;
                end else begin
                    if (beat == BURST) begin
                        rd_valid = 1'b0;
                        ddr_st   = 0;
                        exp_addr = exp_addr + ADDR_W'(BURST);
                        if (exp_addr == ADDR_W'(FRAME)) begin
                            exp_addr = '0;
                            frames_done++;
                        end
                    end else begin
                        rd_valid = 1'b1;
                        rd_data  = 32'(cur_addr) + 32'(beat);
                        sb.push_back(rd_data);
                        beat++;
                    end
                end

                pixel_req = 1'b0;
                if ((pop_mode == 1 && fifo_level >= 2) || (pop_mode == 2 && fifo_level >= 1)) begin
                    if (sb.size() == 0) begin
                        check_eq("scoreboard_size", 64'(sb.size()), 64'd1);
                    end else begin
                        check_eq("hdmi_data", 64'(hdmi_data), 64'(sb.pop_front()));
                    end
                    pixel_req = 1'b1;
                    pop_cnt++;
                end else if (pop_mode == 3) begin
                    check_eq("hdmi_empty_value", 64'(hdmi_data), 64'(EMPTY_VAL));
                    pixel_req = 1'b1;
                end
            end
        end
    end

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_rd_req"}, 64'(rd_req), 64'd0);
        check_eq({pfx, "_rd_addr"}, 64'(rd_addr), 64'd0);
        check_eq({pfx, "_rd_len"}, 64'(rd_len), 64'(BURST));
        check_eq({pfx, "_hdmi_data"}, 64'(hdmi_data), 64'd0);
        check_eq({pfx, "_first_frame"}, 64'(first_frame), 64'd0);
        check_eq({pfx, "_fifo_level"}, 64'(fifo_level), 64'd0);
        check_eq({pfx, "_underflow"}, 64'(underflow), 64'd0);
        check_eq({pfx, "_sync_err"}, 64'(sync_err), 64'd0);
    endtask

    task automatic pulse_tozero();
        tozero = 1'b1;
        @(posedge clk); #1;
        tozero = 1'b0;
    endtask

    // Main scenario sequence
    initial begin
        int t;
        int r0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");

        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_eq("idle_no_req", 64'(rd_req), 64'd0);
        frame_ready = 1'b1;

        // Prefill: first_frame rises one cycle after level hits PRE (two bursts)
        t = 0;
        while (!first_frame && t < 2000) begin @(posedge clk); #1; t++; end
        check_eq("first_frame_rise", 64'(first_frame), 64'd1);
        check_eq("level_at_first_frame", 64'(fifo_level), 64'(PRE));

        // No pops: FIFO fills to depth and no further request is raised
        t = 0;
        while (fifo_level != (AW+1)'(2**AW) && t < 2000) begin @(posedge clk); #1; t++; end
        check_eq("fifo_full", 64'(fifo_level), 64'(2**AW));
        repeat (10) @(posedge clk);
        #1;
        check_eq("no_req_when_full", 64'(rd_req), 64'd0);

        // Stream with consumer, next request held 20 cycles without ack
        hold_token = 1;
        pop_mode   = 1;
        t = 0;
        while (frames_done < 1 && t < 5000) begin @(posedge clk); #1; t++; end
        check_eq("frame1_done", 64'(frames_done), 64'd1);
        check_eq("hold_applied", 64'(hold_used), 64'd1);
        check_eq("no_underflow_streaming", 64'(underflow), 64'd0);
        r0 = req_cycles;

        // Drain completely, then probe underflow with an empty FIFO
        t = 0;
        while (fifo_level >= 2 && t < 1000) begin @(posedge clk); #1; t++; end
        repeat (5) @(posedge clk);
        #1;
        pop_mode = 2;
        t = 0;
        while (fifo_level != 0 && t < 100) begin @(posedge clk); #1; t++; end
        pop_mode = 0;
        check_eq("drained", 64'(fifo_level), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("empty_head", 64'(hdmi_data), 64'(EMPTY_VAL));
        check_eq("underflow_before_probe", 64'(underflow), 64'd0);
        pop_mode = 3;
        @(posedge clk); #1;
        pop_mode = 0;
        @(posedge clk); #1;
        check_eq("underflow_set", 64'(underflow), 64'd1);
        check_eq("underflow_head", 64'(hdmi_data), 64'(EMPTY_VAL));
        check_eq("underflow_level", 64'(fifo_level), 64'd0);
        repeat (10) @(posedge clk);
        #1;
        check_eq("no_req_before_tozero", 64'(req_cycles - r0), 64'd0);
        check_eq("sync_err_clear", 64'(sync_err), 64'd0);

        // Re-arm: next burst starts at address 0 (checked by the DDR model)
        pulse_tozero();
        pop_mode = 1;

        // tozero mid-frame: flagged, fetch continues sequentially
        t = 0;
        while (exp_addr < ADDR_W'(64) && t < 3000) begin @(posedge clk); #1; t++; end
        pulse_tozero();
        repeat (2) @(posedge clk);
        #1;
        check_eq("sync_err_set", 64'(sync_err), 64'd1);
        t = 0;
        while (frames_done < 2 && t < 5000) begin @(posedge clk); #1; t++; end
        check_eq("frame2_done", 64'(frames_done), 64'd2);
        check_eq("underflow_sticky", 64'(underflow), 64'd1);
        check_eq("first_frame_held", 64'(first_frame), 64'd1);

        // Third frame: reset asynchronously in the middle of the second burst
        pulse_tozero();
        t = 0;
        while (!(exp_addr >= ADDR_W'(16) && ddr_st == 2 && beat >= 4) && t < 3000) begin
            @(posedge clk); #1; t++;
        end
        check_eq("mid_data_reached", 64'(ddr_st), 64'd2);
        pop_mode = 0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
